// File: rtl/pipe_addsub_sv.sv
// Pipelined W-bit adder/subtractor: one CW-bit chunk per stage, carry rippling
// through registers, with a single global stall (adv) driven by out_rdy.
module pipe_addsub_sv #(
  parameter int W  = 32,
  parameter int CW = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic         sub,
  input  logic [W-1:0] x_0,
  input  logic [W-1:0] x_1,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic         ovf,
  output logic         busy
);

  localparam int N = (CW > 0) ? W / CW : 0;

  if ((CW < 1) || (N < 1) || ((W % ((CW > 0) ? CW : 1)) != 0)) begin : g_param_check
    $error("pipe_addsub_sv: W must be a positive multiple of CW");
  end

  // One chunk of the add; b is inverted in subtract mode, carry-in completes the negate.
  function automatic logic [CW:0] chunk_add(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                            input logic inv, input logic cin);
    return {1'b0, a} + {1'b0, b ^ {CW{inv}}} + {{CW{1'b0}}, cin};
  endfunction

  logic         adv;
  logic [N-1:0] vld_p;

  assign adv     = !out_vld || out_rdy;
  assign in_rdy  = adv;
  assign out_vld = vld_p[N-1];
  assign busy    = |vld_p;

  for (genvar k = 0; k < N; k++) begin : g_stage
    // Operand bits still to be added (chunks k..N-1) and result bits done so far.
    localparam int RW = W - k * CW;

    logic [RW-1:0]         a_rem;
    logic [RW-1:0]         b_rem;
    logic [(k+1)*CW-1:0]   r_cur;
    logic                  c_in;
    logic                  s_in;
    logic                  v_in;
    logic                  vld_q;
    logic [CW:0]           sum;

    assign sum      = chunk_add(a_rem[CW-1:0], b_rem[CW-1:0], s_in, c_in);
    assign vld_p[k] = vld_q;

    if (k == 0) begin : g_src
      assign a_rem = x_0;
      assign b_rem = x_1;
      assign c_in  = sub;
      assign s_in  = sub;
      assign v_in  = in_vld;
      assign r_cur = sum[CW-1:0];
    end else begin : g_src
      assign a_rem = g_stage[k-1].g_reg.a_p;
      assign b_rem = g_stage[k-1].g_reg.b_p;
      assign c_in  = g_stage[k-1].g_reg.c_p;
      assign s_in  = g_stage[k-1].g_reg.s_p;
      assign v_in  = vld_p[k-1];
      assign r_cur = {sum[CW-1:0], g_stage[k-1].g_reg.r_p};
    end

    always_ff @(posedge clk) begin
      if (resetn || flush) begin
        vld_q <= 1'b0;
      end else if (adv) begin
        vld_q <= v_in;
      end
    end

    if (k < N - 1) begin : g_reg
      // ---- stage k -> k+1 boundary: remaining operand chunks, partial result, carry ----
      logic [RW-CW-1:0]    a_p;
      logic [RW-CW-1:0]    b_p;
      logic [(k+1)*CW-1:0] r_p;
      logic                c_p;
      logic                s_p;

      always_ff @(posedge clk) begin
        if (adv) begin
          a_p <= a_rem[RW-1:CW];
          b_p <= b_rem[RW-1:CW];
          r_p <= r_cur;
          c_p <= sum[CW];
          s_p <= s_in;
        end
      end
    end else begin : g_last
      // ---- output boundary: only real operations update the visible result ----
      always_ff @(posedge clk) begin
        if (resetn) begin
          result <= '0;
          c_out  <= 1'b0;
          ovf    <= 1'b0;
        end else if (adv && v_in && !flush) begin
          result <= r_cur;
          c_out  <= sum[CW];
          ovf    <= (a_rem[CW-1] == (b_rem[CW-1] ^ s_in)) && (sum[CW-1] != a_rem[CW-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_addsub_sv.sv
// Bench for pipe_addsub_sv: directed vector table, stall/flush/reset sequences
// and random traffic on W=32/CW=8, W=16/CW=4 and W=8/CW=8 instances.
module tb_pipe_addsub_sv;

  typedef struct { logic [31:0] r; logic c; logic v; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic s; logic [31:0] r; logic c; logic v; } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        flush = 1'b0;
  logic        in_vld = 1'b0;
  logic        sub = 1'b0;
  logic        out_rdy = 1'b1;
  logic [31:0] x_0 = '0;
  logic [31:0] x_1 = '0;

  logic        in_rdy, out_vld, c_out, ovf, busy;
  logic [31:0] result;
  logic        rdy16, ov16, c16, v16, busy16;
  logic [15:0] res16;
  logic        rdy8, ov8, c8, v8, busy8;
  logic [7:0]  res8;

  always #5 clk = ~clk;

  pipe_addsub_sv #(.W(32), .CW(8)) u_dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy), .sub(sub),
    .x_0(x_0), .x_1(x_1), .out_vld(out_vld), .out_rdy(out_rdy), .result(result),
    .c_out(c_out), .ovf(ovf), .busy(busy));

  pipe_addsub_sv #(.W(16), .CW(4)) u_dut16 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_vld(in_vld), .in_rdy(rdy16), .sub(sub),
    .x_0(x_0[15:0]), .x_1(x_1[15:0]), .out_vld(ov16), .out_rdy(out_rdy), .result(res16),
    .c_out(c16), .ovf(v16), .busy(busy16));

  pipe_addsub_sv #(.W(8), .CW(8)) u_dut8 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_vld(in_vld), .in_rdy(rdy8), .sub(sub),
    .x_0(x_0[7:0]), .x_1(x_1[7:0]), .out_vld(ov8), .out_rdy(out_rdy), .result(res8),
    .c_out(c8), .ovf(v8), .busy(busy8));

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  bit   tbl_mode = 1'b0;
  exp_t tbl_exp;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Reference: unsigned sum for result/carry, signed range test for overflow.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    longint unsigned half, m, ua, ub, u;
    longint          hs, sa, sb, sr;
    half = 64'd1 << (w - 1);
    m    = (half << 1) - 64'd1;
    ua   = {32'd0, a} & m;
    ub   = {32'd0, b} & m;
    u    = s ? (ua + ((~ub) & m) + 64'd1) : (ua + ub);
    e.r  = u[31:0] & m[31:0];
    e.c  = u[w];
    hs   = longint'(half);
    sa   = (ua >= half) ? (longint'(ua) - 2 * hs) : longint'(ua);
    sb   = (ub >= half) ? (longint'(ub) - 2 * hs) : longint'(ub);
    sr   = s ? (sa - sb) : (sa + sb);
    e.v  = (sr >= hs) || (sr < -hs);
    return e;
  endfunction

  task automatic mon(input int id, input int w, input logic irdy, input logic ovld,
                     input logic [31:0] res, input logic c, input logic v);
    exp_t e;
    int   sz;
    if (!resetn && ovld && out_rdy) begin
      sz = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
      n_cmp++;
      if (sz == 0) begin
        n_bad++;
        $display("FAIL out%0d: unexpected result %h, want no output", id, res);
      end else begin
        case (id)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        if (res !== e.r || c !== e.c || v !== e.v) begin
          n_bad++;
          $display("FAIL out%0d: got r=%h c=%b v=%b, want r=%h c=%b v=%b", id, res, c, v, e.r, e.c, e.v);
        end
      end
    end
    if (resetn || flush) begin
      case (id)
        0:       q0.delete();
        1:       q1.delete();
        default: q2.delete();
      endcase
    end else if (in_vld && irdy) begin
      e = (id == 0 && tbl_mode) ? tbl_exp : model(w, x_0, x_1, sub);
      case (id)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  always @(negedge clk) begin
    mon(0, 32, in_rdy, out_vld, result, c_out, ovf);
    mon(1, 16, rdy16, ov16, {16'd0, res16}, c16, v16);
    mon(2, 8, rdy8, ov8, {24'd0, res8}, c8, v8);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, output int tries);
    bit acc = 1'b0;
    tries = 0;
    x_0 = a; x_1 = b; sub = s; in_vld = 1'b1;
    while (!acc && tries < 64) begin
      @(negedge clk);
      acc = in_rdy;
      tries++;
      @(posedge clk);
      #1;
    end
    in_vld = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send: no in_rdy after %0d cycles, want acceptance", tries);
    end
  endtask

  task automatic lat_check(input string name);
    int lat = 0;
    bit seen = 1'b0;
    while (!seen && lat < 16) begin
      @(negedge clk);
      lat++;
      seen = out_vld;
    end
    chk(name, lat, 4);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int i = 0;
    in_vld = 1'b0;
    out_rdy = 1'b1;
    while ((q0.size() + q1.size() + q2.size()) != 0 && i < 200) begin
      tick();
      i++;
    end
    chk(name, q0.size() + q1.size() + q2.size(), 0);
    @(negedge clk);
    chk({name, "_busy"}, {busy, busy16, busy8}, 3'b000);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_8080;
      3:       return 32'h7FFF_7F7F;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[12];
    int          tries;
    logic [33:0] held;
    bit          held_ok;

    tbl[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[2]  = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    tbl[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[6]  = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 32'h2143_6587, 1'b0, 1'b0};
    tbl[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[9]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    tbl[10] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    tbl[11] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

    // Reset state
    resetn = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_vld", {out_vld, ov16, ov8}, 3'b000);
    chk("rst_busy", busy, 0);
    chk("rst_result", {result, c_out, ovf}, 34'd0);
    chk("rst_result16", {res16, c16, v16, res8, c8, v8}, 36'd0);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_in_rdy", in_rdy, 1);
    @(posedge clk);
    #1;

    // Vector table: first one alone for latency, rest streamed back to back
    tbl_mode = 1'b1;
    tbl_exp  = '{tbl[0].r, tbl[0].c, tbl[0].v};
    send(tbl[0].a, tbl[0].b, tbl[0].s, tries);
    lat_check("latency_first");
    drain("drain_first");
    for (int i = 1; i < 12; i++) begin
      tbl_exp = '{tbl[i].r, tbl[i].c, tbl[i].v};
      send(tbl[i].a, tbl[i].b, tbl[i].s, tries);
      chk("no_bubble", tries, 1);
    end
    drain("drain_tbl");
    tbl_mode = 1'b0;

    // Back-pressure: six ops, out_rdy low for seven cycles
    held    = '0;
    held_ok = 1'b0;
    fork
      begin
        int t;
        for (int i = 0; i < 6; i++) begin
          send(32'h1357_9BDF * (i + 1), 32'h0F0F_0F0F ^ i, (i % 2) == 1, t);
        end
      end
      begin
        tick();
        out_rdy = 1'b0;
        for (int c = 0; c < 7; c++) begin
          @(negedge clk);
          if (out_vld) begin
            chk("stall_in_rdy", in_rdy, 0);
            if (held_ok) chk("stall_hold", {result, c_out, ovf}, held);
            held    = {result, c_out, ovf};
            held_ok = 1'b1;
          end
          @(posedge clk);
          #1;
        end
        chk("stall_vld_seen", held_ok, 1);
        out_rdy = 1'b1;
      end
    join
    drain("drain_stall");

    // Flush with three operations in flight; an op offered during flush is dropped
    send(32'h0000_1111, 32'h0000_2222, 1'b0, tries);
    send(32'h0000_3333, 32'h0000_4444, 1'b0, tries);
    send(32'h0000_5555, 32'h0000_6666, 1'b1, tries);
    held   = {result, c_out, ovf};
    flush  = 1'b1;
    x_0    = 32'hDEAD_BEEF;
    x_1    = 32'h0000_0001;
    sub    = 1'b0;
    in_vld = 1'b1;
    @(negedge clk);
    chk("flush_busy_before", busy, 1);
    @(posedge clk);
    #1;
    flush  = 1'b0;
    in_vld = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_out_vld", out_vld, 0);
    chk("flush_hold", {result, c_out, ovf}, held);
    @(posedge clk);
    #1;
    send(32'hA5A5_0000, 32'h0000_5A5A, 1'b0, tries);
    lat_check("latency_after_flush");
    drain("drain_flush");

    // Reset in the middle of a stream
    for (int i = 0; i < 5; i++) send(32'h0101_0101 * (i + 3), 32'h00FF_00FF, 1'b0, tries);
    resetn = 1'b1;
    in_vld = 1'b1;
    tick();
    resetn = 1'b0;
    in_vld = 1'b0;
    @(negedge clk);
    chk("midrst_out_vld", {out_vld, ov16, ov8}, 3'b000);
    chk("midrst_busy", {busy, busy16, busy8}, 3'b000);
    chk("midrst_result", {result, c_out, ovf}, 34'd0);
    chk("midrst_in_rdy", in_rdy, 1);
    @(posedge clk);
    #1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("midrst_no_stale", {out_vld, ov16, ov8}, 3'b000);
      @(posedge clk);
      #1;
    end

    // Random traffic with random back-pressure and occasional flush
    for (int c = 0; c < 600; c++) begin
      in_vld  = ($urandom_range(0, 3) != 0);
      x_0     = pick();
      x_1     = pick();
      sub     = ($urandom_range(0, 1) == 1);
      out_rdy = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 63) == 0);
      tick();
    end
    flush = 1'b0;
    drain("drain_rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
